// File: rtl/pulse_sync_pkg.sv
// Shared definitions for the pulse synchronizer receive side: default
// parameter values and the handshake FSM state encoding.
package pulse_sync_pkg;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int CNT_W_DEF       = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a new request level
    PEND = 2'd1,  // request seen, consumer not yet ready
    ACK  = 2'd2,  // pulse delivered, acknowledge held high
    DROP = 2'd3   // acknowledge released, one settling cycle
  } state_e;

endpackage

// File: rtl/pulse_sync_rx_if.sv
// Handshake bundle between the source domain, the consumer and the
// pulse_sync_rx block. The slave side is the receiver itself.
interface pulse_sync_rx_if #(
  parameter int CNT_W = pulse_sync_pkg::CNT_W_DEF
) ();

  logic             req_a;        // four-phase request level, source domain
  logic             rdy_b;        // consumer ready
  logic             ack_b;        // four-phase acknowledge level
  logic             pulse_outb;   // single-cycle delivered pulse
  logic             signal_outb;  // high from delivery until release
  logic             busy_b;       // receiver FSM not idle
  logic [CNT_W-1:0] pulse_cnt;    // delivered pulse count

  modport slave (
    input  req_a, rdy_b,
    output ack_b, pulse_outb, signal_outb, busy_b, pulse_cnt
  );

  modport master (
    output req_a, rdy_b,
    input  ack_b, pulse_outb, signal_outb, busy_b, pulse_cnt
  );

endinterface

// File: rtl/sync_cell.sv
// Multi-flop level synchronizer. Only the final stage is meant to feed
// downstream logic; the earlier stages exist to let metastability settle.
module sync_cell #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  // Shift the asynchronous input through the flop chain.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every synchronizer stage is reset so a stale request level can
    // never survive reset and be mistaken for a fresh one afterwards.
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pulse_sync_rx.sv
// Receive side of a four-phase pulse synchronizer. A request level from an
// asynchronous source is synchronized, turned into exactly one pulse when
// the consumer is ready, acknowledged back, and released once the source
// drops its request.
module pulse_sync_rx
  import pulse_sync_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic            clkb,
  input  logic            rst_n,
  pulse_sync_rx_if.slave  bus
);

  logic             req_s;
  logic             deliver;
  state_e           state_q;
  logic             ack_q;
  logic             pulse_q;
  logic             signal_q;
  logic [CNT_W-1:0] cnt_q;

  sync_cell #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clkb),
    .rst_n (rst_n),
    .d     (bus.req_a),
    .q     (req_s)
  );

  // A pulse is delivered when a live request meets a ready consumer while no
  // handshake is in flight. A request that drops in PEND wins over a ready
  // consumer in the same cycle: the source has withdrawn it.
  assign deliver = req_s && bus.rdy_b && (state_q == IDLE || state_q == PEND);

  // Handshake FSM with registered outputs and the delivered-pulse counter.
  always_ff @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      ack_q    <= 1'b0;
      pulse_q  <= 1'b0;
      signal_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments so every read in
      // this block sees the pre-edge value, regardless of statement order.
      pulse_q <= 1'b0;
      if (deliver) begin
        state_q  <= ACK;
        ack_q    <= 1'b1;
        pulse_q  <= 1'b1;
        signal_q <= 1'b1;
        cnt_q    <= cnt_q + CNT_W'(1);
      end else begin
        case (state_q)
          IDLE: if (req_s) state_q <= PEND;
          PEND: if (!req_s) state_q <= IDLE;
          ACK: begin
            if (!req_s) begin
              state_q  <= DROP;
              ack_q    <= 1'b0;
              signal_q <= 1'b0;
            end
          end
          DROP:    state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.ack_b       = ack_q;
  assign bus.pulse_outb  = pulse_q;
  assign bus.signal_outb = signal_q;
  assign bus.busy_b      = (state_q != IDLE);
  assign bus.pulse_cnt   = cnt_q;

endmodule

// File: tb/tb_pulse_sync_rx.sv
// Self-checking bench for pulse_sync_rx: directed handshake scenarios plus a
// randomized phase, all scored against a protocol-level reference model.
module tb_pulse_sync_rx;
  import pulse_sync_pkg::*;

  localparam int SYNC = 2;
  localparam int CW   = 8;

  typedef struct {
    int cyc;
    int cnt;
  } exp_t;

  logic clkb  = 1'b0;
  logic rst_n = 1'b0;

  always #5 clkb = ~clkb;

  pulse_sync_rx_if #(.CNT_W(CW)) bus ();

  pulse_sync_rx #(
    .SYNC_STAGES (SYNC),
    .CNT_W       (CW)
  ) dut (
    .clkb  (clkb),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  int pulses_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the synchronizer is a pure delay of sampled req_a; the
  // protocol is "one pulse per request phase, once the consumer is ready;
  // acknowledge holds until the request drops, then one quiet cycle".
  logic [SYNC-1:0] m_hist;
  logic            m_rs;
  bit              m_wait, m_ack, m_cool;
  int              m_cnt;
  int              cyc = 0;
  exp_t            exp_q[$];
  exp_t            e;

  always @(posedge clkb or negedge rst_n) begin
    if (!rst_n) begin
      m_hist = '0;
      m_wait = 0;
      m_ack  = 0;
      m_cool = 0;
      m_cnt  = 0;
      exp_q.delete();
    end else begin
      cyc++;
      m_rs = m_hist[SYNC-1];
      if (m_cool) begin
        m_cool = 0;
      end else if (m_ack) begin
        if (!m_rs) begin
          m_ack  = 0;
          m_cool = 1;
        end
      end else if (m_rs && bus.rdy_b) begin
        m_wait = 0;
        m_ack  = 1;
        m_cnt  = (m_cnt + 1) % (1 << CW);
        exp_q.push_back('{cyc, m_cnt});
      end else begin
        m_wait = m_rs;
      end
      m_hist = {m_hist[SYNC-2:0], bus.req_a};
    end
  end

  // Monitor: pops an expected pulse whenever the DUT shows one, flags missing
  // pulses, and compares the handshake levels every cycle.
  always @(negedge clkb) begin
    if (rst_n) begin
      if (bus.pulse_outb === 1'b1) begin
        pulses_seen++;
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", bus.pulse_outb, 0);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_cnt_at_pulse", bus.pulse_cnt, e.cnt);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        check("missed_pulse", bus.pulse_outb, 1);
      end
      check("ack_level", bus.ack_b, m_ack);
      check("signal_level", bus.signal_outb, m_ack);
      check("busy_level", bus.busy_b, m_ack | m_wait | m_cool);
      check("cnt_level", bus.pulse_cnt, m_cnt);
    end
  end

  // Wait n rising edges, then settle on the following falling edge.
  task automatic after_edges(input int n);
    repeat (n) @(posedge clkb);
    @(negedge clkb);
  endtask

  initial begin
    int k;
    bus.req_a = 1'b0;
    bus.rdy_b = 1'b0;

    // Reset state
    #12;
    check("rst_ack", bus.ack_b, 0);
    check("rst_pulse", bus.pulse_outb, 0);
    check("rst_signal", bus.signal_outb, 0);
    check("rst_busy", bus.busy_b, 0);
    check("rst_cnt", bus.pulse_cnt, 0);
    @(negedge clkb);
    rst_n = 1'b1;
    after_edges(2);

    // Basic latency: pulse after edge SYNC+1
    bus.rdy_b = 1'b1;
    bus.req_a = 1'b1;
    after_edges(2);
    check("lat_early_pulse", bus.pulse_outb, 0);
    after_edges(1);
    check("lat_pulse", bus.pulse_outb, 1);
    check("lat_ack", bus.ack_b, 1);
    check("lat_cnt", bus.pulse_cnt, 1);
    after_edges(1);
    check("pulse_one_cycle", bus.pulse_outb, 0);

    // Long request phase yields a single pulse
    repeat (200) after_edges(1);
    #1 check("long_req_one_pulse", pulses_seen, 1);

    // Release timing
    bus.req_a = 1'b0;
    after_edges(2);
    check("rel_ack_held", bus.ack_b, 1);
    after_edges(1);
    check("rel_ack", bus.ack_b, 0);
    check("rel_signal", bus.signal_outb, 0);
    check("rel_busy_drop", bus.busy_b, 1);
    after_edges(1);
    check("rel_busy_idle", bus.busy_b, 0);

    // Consumer not ready: wait in PEND, deliver on the first ready cycle
    bus.rdy_b = 1'b0;
    bus.req_a = 1'b1;
    after_edges(10);
    check("pend_state", dut.state_q, PEND);
    check("pend_busy", bus.busy_b, 1);
    check("pend_no_pulse", bus.pulse_cnt, 1);
    bus.rdy_b = 1'b1;
    after_edges(1);
    check("pend_pulse", bus.pulse_outb, 1);
    check("pend_cnt", bus.pulse_cnt, 2);
    bus.req_a = 1'b0;
    after_edges(6);

    // Source abort while waiting
    bus.rdy_b = 1'b0;
    bus.req_a = 1'b1;
    after_edges(4);
    check("abort_busy", bus.busy_b, 1);
    bus.req_a = 1'b0;
    after_edges(6);
    check("abort_cnt", bus.pulse_cnt, 2);
    check("abort_idle", bus.busy_b, 0);
    #1 check("abort_pulses", pulses_seen, 2);

    // Reset in the middle of a handshake, request held through release
    bus.rdy_b = 1'b1;
    bus.req_a = 1'b1;
    after_edges(5);
    check("mid_ack_before", bus.ack_b, 1);
    #1 rst_n = 1'b0;
    #1 check("mid_rst_ack", bus.ack_b, 0);
    check("mid_rst_cnt", bus.pulse_cnt, 0);
    #1 rst_n = 1'b1;
    after_edges(20);
    check("mid_new_cnt", bus.pulse_cnt, 1);
    #1 check("mid_pulses", pulses_seen, 4);
    bus.req_a = 1'b0;
    after_edges(6);

    // Back-to-back handshakes with counter wrap
    #1 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    after_edges(2);
    for (int i = 0; i < 300; i++) begin
      bus.req_a = 1'b1;
      k = 0;
      while (bus.ack_b !== 1'b1 && k < 20) begin
        after_edges(1);
        k++;
      end
      check("hs_ack", bus.ack_b, 1);
      bus.req_a = 1'b0;
      k = 0;
      while (bus.busy_b !== 1'b0 && k < 20) begin
        after_edges(1);
        k++;
      end
      check("hs_idle", bus.busy_b, 0);
    end
    check("wrap_cnt", bus.pulse_cnt, 300 % (1 << CW));

    // Randomized request/ready activity against the model
    for (int i = 0; i < 300; i++) begin
      bus.req_a = 1'($urandom_range(0, 1));
      bus.rdy_b = 1'($urandom_range(0, 1));
      after_edges($urandom_range(1, 6));
    end
    bus.req_a = 1'b0;
    bus.rdy_b = 1'b1;
    after_edges(10);
    check("queue_drained", exp_q.size(), 0);
    check("final_idle", bus.busy_b, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pulse_sync_rx.md
PULSE_SYNC_RX -- requirements
Module: pulse_sync_rx

Interface
REQ-001: Parameter SYNC_STAGES, default 2, SHALL be the number of synchronizer flops on req_a, legal range 2..4.
REQ-002: Parameter CNT_W, default 8, SHALL be the width of the delivered-pulse counter.
REQ-003: Port clkb, input, 1: the single destination clock; all state SHALL be clocked on its rising edge.
REQ-004: Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005: Port req_a, input, 1: four-phase request level from the source domain, asynchronous to clkb.
REQ-006: Port rdy_b, input, 1: consumer ready; high means a pulse may be delivered this cycle.
REQ-007: Port ack_b, output, 1: four-phase acknowledge level returned to the source domain, registered.
REQ-008: Port pulse_outb, output, 1: single-cycle delivered pulse, registered.
REQ-009: Port signal_outb, output, 1: level high from delivery until handshake release, registered.
REQ-010: Port busy_b, output, 1: high whenever the FSM is not IDLE.
REQ-011: Port pulse_cnt, output, CNT_W: count of delivered pulses.

Function
REQ-012: req_a SHALL pass only through a SYNC_STAGES-deep flop chain; only the last stage (req_s) SHALL feed logic.
REQ-013: FSM states SHALL be IDLE, PEND, ACK and DROP.
REQ-014: IDLE SHALL move to PEND on req_s=1 with rdy_b=0, or directly to ACK on req_s=1 with rdy_b=1.
REQ-015: PEND SHALL move to ACK on the first cycle rdy_b=1, holding indefinitely otherwise.
REQ-016: PEND SHALL return to IDLE without delivery if req_s falls before rdy_b=1 (source abort); pulse_cnt unchanged.
REQ-017: Entry into ACK SHALL assert pulse_outb for exactly one cycle, set ack_b=1 and signal_outb=1, and increment pulse_cnt.
REQ-018: ACK SHALL move to DROP when req_s=0, clearing ack_b and signal_outb on that transition.
REQ-019: DROP SHALL move to IDLE after one cycle; a req_s=1 seen in DROP SHALL only be acted on from IDLE.
REQ-020: Latency SHALL be as follows. If edge 1 is the first clkb edge sampling req_a=1 and rdy_b=1, pulse_outb SHALL be high in the cycle after edge SYNC_STAGES+1.
REQ-021: pulse_cnt SHALL wrap from 2^CNT_W-1 to 0, with no overflow flag.
REQ-022: req_s already high when reset releases SHALL be treated as a new request, entering PEND or ACK per REQ-014.
REQ-023: Only one pulse SHALL be delivered per req_a high phase, regardless of its duration.

Reset
REQ-024: rst_n low SHALL immediately clear all sync flops, the FSM (to IDLE), ack_b, pulse_outb, signal_outb, busy_b and pulse_cnt to 0.
REQ-025: Reset asserted mid-handshake SHALL drop ack_b to 0 with no further pulse until a fresh req_s=1 is observed in IDLE after release.

Structure
REQ-026: Package pulse_sync_pkg SHALL hold the FSM state enum and the SYNC_STAGES and CNT_W defaults.
REQ-027: The synchronizer chain SHALL be a separate sub-module, sync_cell (parameter STAGES, ports clk, rst_n, d, q), reusable by the source side.

Verification
REQ-028: SYNC_STAGES=2, rdy_b=1, req_a rises -> pulse_outb high one cycle after edge 3, ack_b=1, pulse_cnt 0->1.
REQ-029: After REQ-028, req_a falls -> ack_b and signal_outb go 0 three edges later, busy_b 0 one edge after that.
REQ-030: rdy_b=0 for 10 cycles while req_a=1 -> state PEND, no pulse; rdy_b rises -> pulse next edge.
REQ-031: req_a high 200 cycles -> exactly one pulse_outb; then 300 back-to-back handshakes with CNT_W=8 -> pulse_cnt ends at 44 (300 mod 256).
REQ-032: rst_n pulsed low while in ACK -> ack_b 0 asynchronously; req_a held high through release -> one new pulse.
REQ-033: req_a raised and dropped while rdy_b=0 -> PEND back to IDLE, pulse_cnt unchanged.
